// File: rtl/dig_timer_controller_if.sv
// Control/status bundle for dig_timer_controller: arm/abort/ack inputs
// and the counter, busy and expiry flag outputs.
interface dig_timer_controller_if #(
   parameter int Bits = 8
);
   logic            start;
   logic            stop;
   logic            mode;
   logic [Bits-1:0] period;
   logic            en;
   logic            ack;
   logic [Bits-1:0] count;
   logic            busy;
   logic            done;
   logic            irq;
   logic            ovr;

   modport master (
      output start, stop, mode, period, en, ack,
      input  count, busy, done, irq, ovr
   );

   modport slave (
      input  start, stop, mode, period, en, ack,
      output count, busy, done, irq, ovr
   );
endinterface

// File: rtl/dig_timer_controller.sv
// Down-counting interval timer with one-shot/periodic modes, a registered
// expiry pulse and sticky irq/overrun flags.
module dig_timer_controller #(
   parameter int Bits = 8
) (
   input  logic                    C,
   input  logic                    clr,
   dig_timer_controller_if.slave   bus
);

   if (Bits < 2) begin : g_bits_check
      $error("dig_timer_controller: Bits must be at least 2");
   end

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]      r_state;
   logic [Bits-1:0] r_count;
   logic [Bits-1:0] r_pl;
   logic            r_ml;
   logic            r_done;
   logic            r_irq;
   logic            r_ovr;

   logic            w_run;
   logic            w_expire;
   logic [Bits-1:0] w_start_load;
   logic [Bits-1:0] w_reload;

   assign w_run        = (r_state == ST_RUN);
   assign w_expire     = w_run && bus.en && (r_count == '0);
   // Subtracting 1 wraps period 0 to all ones, encoding N = 2^Bits.
   assign w_start_load = bus.period - 1'b1;
   assign w_reload     = r_pl - 1'b1;

   always_ff @(posedge C) begin
      if (clr) begin
         r_state <= ST_IDLE;
         r_count <= '0;
         r_pl    <= '0;
         r_ml    <= 1'b0;
         r_done  <= 1'b0;
         r_irq   <= 1'b0;
         r_ovr   <= 1'b0;
      end else if (bus.stop) begin
         r_state <= ST_IDLE;
         r_count <= '0;
         r_done  <= 1'b0;
      end else if (bus.start) begin
         // A (re)start wins over a coincident expiry, so only ack can touch the flags.
         r_state <= ST_RUN;
         r_pl    <= bus.period;
         r_ml    <= bus.mode;
         r_count <= w_start_load;
         r_done  <= 1'b0;
         if (bus.ack) begin
            r_irq <= 1'b0;
            r_ovr <= 1'b0;
         end
      end else if (w_expire) begin
         r_done <= 1'b1;
         r_irq  <= 1'b1;
         if (bus.ack) begin
            r_ovr <= 1'b0;
         end else if (r_irq) begin
            r_ovr <= 1'b1;
         end
         if (r_ml) begin
            r_count <= w_reload;
         end else begin
            r_state <= ST_IDLE;
            r_count <= '0;
         end
      end else begin
         r_done <= 1'b0;
         if (w_run && bus.en) begin
            r_count <= r_count - 1'b1;
         end
         if (bus.ack) begin
            r_irq <= 1'b0;
            r_ovr <= 1'b0;
         end
      end
   end

   assign bus.count = r_count;
   assign bus.busy  = w_run;
   assign bus.done  = r_done;
   assign bus.irq   = r_irq;
   assign bus.ovr   = r_ovr;

endmodule

// File: tb/tb_dig_timer_controller.sv
// Bench for dig_timer_controller: Bits=8 and Bits=4 instances share stimulus
// and are compared every cycle against a tick-counting reference model.
module tb_dig_timer_controller;

   logic C;
   logic clr;

   dig_timer_controller_if #(.Bits(8)) bus8 ();
   dig_timer_controller_if #(.Bits(4)) bus4 ();

   dig_timer_controller #(.Bits(8)) u_dut8 (.C(C), .clr(clr), .bus(bus8.slave));
   dig_timer_controller #(.Bits(4)) u_dut4 (.C(C), .clr(clr), .bus(bus4.slave));

   initial begin
      C = 1'b0;
      forever #5 C = ~C;
   end

   // Reference model: an armed timer of length N expires on the N-th
   // en-qualified edge after it was loaded; count is the remaining ticks.
   typedef struct {
      bit run;
      bit per;
      int n;
      int ticks;
      bit done;
      bit irq;
      bit ovr;
   } mdl_t;

   mdl_t m[2];
   int   bw[2];

   bit   s_clr, s_start, s_stop, s_mode, s_en, s_ack;
   int   s_period;

   int   checks;
   int   failures;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input int i);
      int p;
      if (s_clr) begin
         m[i].run = 0; m[i].per = 0; m[i].n = 1; m[i].ticks = 0;
         m[i].done = 0; m[i].irq = 0; m[i].ovr = 0;
      end else if (s_stop) begin
         m[i].run = 0; m[i].done = 0;
      end else if (s_start) begin
         p = s_period % (1 << bw[i]);
         m[i].n = (p == 0) ? (1 << bw[i]) : p;
         m[i].per = s_mode; m[i].ticks = 0; m[i].run = 1; m[i].done = 0;
         if (s_ack) begin m[i].irq = 0; m[i].ovr = 0; end
      end else if (m[i].run && s_en && m[i].ticks == m[i].n - 1) begin
         m[i].done = 1;
         if (s_ack) m[i].ovr = 0;
         else if (m[i].irq) m[i].ovr = 1;
         m[i].irq = 1;
         m[i].ticks = 0;
         if (!m[i].per) m[i].run = 0;
      end else begin
         m[i].done = 0;
         if (m[i].run && s_en) m[i].ticks++;
         if (s_ack) begin m[i].irq = 0; m[i].ovr = 0; end
      end
   endtask

   function automatic int exp_count(input int i);
      return m[i].run ? (m[i].n - 1 - m[i].ticks) : 0;
   endfunction

   task automatic check_all(input string tag);
      chk({tag, "/8.count"}, 32'(bus8.count), 32'(exp_count(0)));
      chk({tag, "/8.busy"},  32'(bus8.busy),  32'(m[0].run));
      chk({tag, "/8.done"},  32'(bus8.done),  32'(m[0].done));
      chk({tag, "/8.irq"},   32'(bus8.irq),   32'(m[0].irq));
      chk({tag, "/8.ovr"},   32'(bus8.ovr),   32'(m[0].ovr));
      chk({tag, "/4.count"}, 32'(bus4.count), 32'(exp_count(1)));
      chk({tag, "/4.busy"},  32'(bus4.busy),  32'(m[1].run));
      chk({tag, "/4.done"},  32'(bus4.done),  32'(m[1].done));
      chk({tag, "/4.irq"},   32'(bus4.irq),   32'(m[1].irq));
      chk({tag, "/4.ovr"},   32'(bus4.ovr),   32'(m[1].ovr));
   endtask

   // One clock: drive inputs, take the edge, advance the model, compare.
   task automatic cyc(input string tag, input bit c, input bit st, input bit sp,
                      input bit md, input int pd, input bit e, input bit a);
      logic [7:0] p8;
      s_clr = c; s_start = st; s_stop = sp; s_mode = md; s_period = pd;
      s_en = e; s_ack = a;
      p8 = 8'(pd);
      clr = c;
      bus8.start = st; bus8.stop = sp; bus8.mode = md; bus8.period = p8;
      bus8.en = e; bus8.ack = a;
      bus4.start = st; bus4.stop = sp; bus4.mode = md; bus4.period = p8[3:0];
      bus4.en = e; bus4.ack = a;
      @(posedge C);
      #1;
      model_edge(0);
      model_edge(1);
      check_all(tag);
   endtask

   initial begin
      checks = 0; failures = 0;
      bw[0] = 8; bw[1] = 4;
      for (int i = 0; i < 2; i++) begin
         m[i].run = 0; m[i].per = 0; m[i].n = 1; m[i].ticks = 0;
         m[i].done = 0; m[i].irq = 0; m[i].ovr = 0;
      end
      @(negedge C);

      cyc("reset0", 1, 0, 0, 0, 0, 0, 0);
      cyc("reset1", 1, 1, 0, 1, 9, 1, 0);
      cyc("idle_en", 0, 0, 0, 0, 0, 1, 0);
      cyc("idle_stop", 0, 0, 1, 0, 0, 1, 0);

      // One-shot, period 3
      cyc("os_start", 0, 1, 0, 0, 3, 1, 0);
      chk("os_cnt_e0", 32'(bus8.count), 32'd2);
      cyc("os_e1", 0, 0, 0, 0, 0, 1, 0);
      chk("os_cnt_e1", 32'(bus8.count), 32'd1);
      cyc("os_e2", 0, 0, 0, 0, 0, 1, 0);
      chk("os_cnt_e2", 32'(bus8.count), 32'd0);
      cyc("os_e3", 0, 0, 0, 0, 0, 1, 0);
      chk("os_done_e3", 32'(bus8.done), 32'd1);
      chk("os_busy_e3", 32'(bus8.busy), 32'd0);
      chk("os_irq_e3", 32'(bus8.irq), 32'd1);
      cyc("os_e4", 0, 0, 0, 0, 0, 1, 0);
      chk("os_done_e4", 32'(bus8.done), 32'd0);
      cyc("os_ack", 0, 0, 0, 0, 0, 1, 1);

      // Periodic, period 2
      cyc("per_e0", 0, 1, 0, 1, 2, 1, 0);
      for (int k = 1; k <= 6; k++) begin
         cyc("per_run", 0, 0, 0, 0, 0, 1, (k == 5));
         if (k == 4) chk("per_ovr_e4", 32'(bus8.ovr), 32'd1);
         if (k == 5) chk("per_ack_e5", 32'({bus8.irq, bus8.ovr}), 32'd0);
         if (k == 6) chk("per_irq_e6", 32'(bus8.irq), 32'd1);
         if (k == 2 || k == 4 || k == 6) chk("per_done", 32'(bus8.done), 32'd1);
      end
      // ack on an expiry edge: irq stays set, ovr clears
      cyc("per_e7", 0, 0, 0, 0, 0, 1, 0);
      cyc("per_e8_ack", 0, 0, 0, 0, 0, 1, 1);
      chk("ack_on_exp", 32'({bus8.irq, bus8.ovr}), 32'b10);
      cyc("per_stop", 0, 0, 1, 0, 0, 1, 0);
      cyc("ack2", 0, 0, 0, 0, 0, 0, 1);

      // Period 0: N = 2^Bits (16 for the 4-bit instance, 256 for the 8-bit)
      cyc("p0_start", 0, 1, 0, 0, 0, 1, 0);
      chk("p0_cnt4", 32'(bus4.count), 32'd15);
      chk("p0_cnt8", 32'(bus8.count), 32'd255);
      for (int k = 1; k <= 260; k++) begin
         cyc("p0_run", 0, 0, 0, 0, 0, 1, 0);
         if (k == 16) chk("p0_done4", 32'(bus4.done), 32'd1);
         if (k == 256) chk("p0_done8", 32'(bus8.done), 32'd1);
      end
      cyc("ack3", 0, 0, 0, 0, 0, 0, 1);

      // Alternate-cycle en gating, period 3
      cyc("gate_start", 0, 1, 0, 0, 3, 0, 0);
      for (int k = 1; k <= 8; k++) begin
         cyc("gate_run", 0, 0, 0, 0, 0, k[0], 0);
         if (k == 2) chk("gate_hold", 32'(bus8.count), 32'd1);
         if (k == 5) chk("gate_done", 32'(bus8.done), 32'd1);
      end

      // start+stop in RUN; restart on an expiry edge
      cyc("pr_start", 0, 1, 0, 1, 4, 1, 0);
      cyc("pr_both", 0, 1, 1, 0, 6, 1, 0);
      chk("pr_both_cnt", 32'(bus8.count), 32'd0);
      cyc("pr_arm", 0, 1, 0, 0, 2, 1, 0);
      cyc("pr_e1", 0, 0, 0, 0, 0, 1, 0);
      cyc("pr_restart", 0, 1, 0, 0, 5, 1, 0);
      chk("pr_restart_cnt", 32'(bus8.count), 32'd4);
      chk("pr_restart_done", 32'(bus8.done), 32'd0);
      for (int k = 0; k < 5; k++) cyc("pr_run", 0, 0, 0, 0, 0, 1, 0);

      // clr mid-RUN with count 7 and irq set
      cyc("clr_arm", 0, 1, 0, 0, 10, 1, 0);
      cyc("clr_e1", 0, 0, 0, 0, 0, 1, 0);
      cyc("clr_e2", 0, 0, 0, 0, 0, 1, 0);
      chk("clr_pre_cnt", 32'(bus8.count), 32'd7);
      chk("clr_pre_irq", 32'(bus8.irq), 32'd1);
      cyc("clr_mid", 1, 1, 0, 1, 3, 1, 0);
      chk("clr_post", 32'({bus8.busy, bus8.count, bus8.irq, bus8.ovr, bus8.done}), 32'd0);

      // Period 1 periodic: done every cycle
      cyc("p1_start", 0, 1, 0, 1, 1, 1, 0);
      for (int k = 0; k < 4; k++) cyc("p1_run", 0, 0, 0, 0, 0, 1, 0);
      chk("p1_done", 32'(bus8.done), 32'd1);

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         int pd;
         pd = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                          : int'($urandom_range(0, 6));
         cyc("rand", ($urandom_range(0, 149) == 0), ($urandom_range(0, 11) == 0),
             ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), pd,
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
